// File: rtl/mips_data_ram_harvard.sv
// Harvard data-side RAM for the MIPS core: word-addressed window with sticky protocol-error flags; DATA_RAM_STATS_EN adds access statistics.
// Latency: combinational read (zero cycles), writes committed on posedge clk.
// Backpressure: none, always ready; clock_enable low freezes writes, flags and counters while reads stay live.
module mips_data_ram_harvard #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          DEPTH_WORDS = 1024,
    parameter              INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clock_enable,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic        err_misaligned,
    output logic        err_range,
    output logic        err_conflict
`ifdef DATA_RAM_STATS_EN
    ,
    output logic [31:0] read_count,
    output logic [31:0] write_count,
    output logic [31:0] last_err_address
`endif
);

    localparam int          IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI = WIN_LO + 33'(4 * DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    logic             in_range;
    logic             aligned;
    logic             access;
    logic             rd_ok;
    logic             wr_ok;
    logic             cond_misaligned;
    logic             cond_range;
    logic             cond_conflict;
    logic [IDX_W-1:0] idx;

    // Window compare is done in 33 bits so a window touching 4 GiB cannot wrap.
    assign in_range = ({1'b0, data_address} >= WIN_LO) && ({1'b0, data_address} < WIN_HI);
    assign aligned  = (data_address[1:0] == 2'b00);
    assign access   = data_read | data_write;
    assign idx      = IDX_W'((data_address - BASE_ADDR) >> 2);
    assign rd_ok    = data_read  && in_range && aligned;
    assign wr_ok    = data_write && in_range && aligned;

    assign cond_misaligned = access && !aligned;
    assign cond_range      = access && !in_range;
    assign cond_conflict   = data_read && data_write;

    // Read sees the pre-edge array, so a same-cycle write to the same word returns the old value.
    assign data_readdata = (rd_ok && !reset) ? mem[idx] : 32'h0;

    always_ff @(posedge clk) begin
        if (clock_enable && !reset && wr_ok) begin
            mem[idx] <= data_writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_misaligned <= 1'b0;
            err_range      <= 1'b0;
            err_conflict   <= 1'b0;
        end else if (clock_enable) begin
            err_misaligned <= err_misaligned | cond_misaligned;
            err_range      <= err_range      | cond_range;
            err_conflict   <= err_conflict   | cond_conflict;
        end
    end

`ifdef DATA_RAM_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            read_count       <= 32'h0;
            write_count      <= 32'h0;
            last_err_address <= 32'h0;
        end else if (clock_enable) begin
            if (rd_ok && (read_count != 32'hFFFF_FFFF)) begin
                read_count <= read_count + 32'd1;
            end
            if (wr_ok && (write_count != 32'hFFFF_FFFF)) begin
                write_count <= write_count + 32'd1;
            end
            if (cond_misaligned || cond_range || cond_conflict) begin
                last_err_address <= data_address;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mips_data_ram_harvard.sv
// Bench for mips_data_ram_harvard: directed steps followed by random traffic, checked against an associative-array memory model.
module tb_mips_data_ram_harvard;

    logic        clk = 1'b0;
    logic        reset;
    logic        clock_enable;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic        err_misaligned;
    logic        err_range;
    logic        err_conflict;
`ifdef DATA_RAM_STATS_EN
    logic [31:0] read_count;
    logic [31:0] write_count;
    logic [31:0] last_err_address;
`endif

    always #5 clk = ~clk;

    mips_data_ram_harvard dut (
        .clk            (clk),
        .reset          (reset),
        .clock_enable   (clock_enable),
        .data_address   (data_address),
        .data_read      (data_read),
        .data_write     (data_write),
        .data_writedata (data_writedata),
        .data_readdata  (data_readdata),
        .err_misaligned (err_misaligned),
        .err_range      (err_range),
        .err_conflict   (err_conflict)
`ifdef DATA_RAM_STATS_EN
        ,
        .read_count       (read_count),
        .write_count      (write_count),
        .last_err_address (last_err_address)
`endif
    );

    localparam longint BASE  = 64'h1000;
    localparam longint WORDS = 1024;

    int          checks   = 0;
    int          failures = 0;
    string       phase    = "init";
    logic [31:0] ref_mem [int];
    bit          m_mis, m_rng, m_cfl;
    logic [31:0] m_rc, m_wc, m_lea;
    logic [31:0] obs_rd;
    logic [31:0] saved;

    function automatic bit in_win(logic [31:0] a);
        return (longint'(a) >= BASE) && (longint'(a) < BASE + 4 * WORDS);
    endfunction

    function automatic bit valid_addr(logic [31:0] a);
        return in_win(a) && (a % 4 == 0);
    endfunction

    function automatic logic [31:0] model_word(logic [31:0] a);
        int key;
        key = int'((longint'(a) - BASE) / 4);
        return ref_mem.exists(key) ? ref_mem[key] : 32'h0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s:%s observed=%h expected=%h", phase, tag, obs, exp);
        end
    endtask

    // One bus cycle: check combinational read before the edge, then advance the model and check state after it.
    task automatic cycle(bit rst, bit ce, bit rd, bit wr, logic [31:0] addr, logic [31:0] wd);
        logic [31:0] exp_rd;
        bit          em, er, ec;
        reset          = rst;
        clock_enable   = ce;
        data_read      = rd;
        data_write     = wr;
        data_address   = addr;
        data_writedata = wd;
        #1;
        exp_rd = (!rst && rd && valid_addr(addr)) ? model_word(addr) : 32'h0;
        obs_rd = data_readdata;
        chk("readdata", obs_rd, exp_rd);
        @(posedge clk);
        #1;
        if (rst) begin
            m_mis = 0; m_rng = 0; m_cfl = 0;
            m_rc = 0; m_wc = 0; m_lea = 0;
        end else if (ce) begin
            if (wr && valid_addr(addr)) ref_mem[int'((longint'(addr) - BASE) / 4)] = wd;
            em = (rd || wr) && (addr % 4 != 0);
            er = (rd || wr) && !in_win(addr);
            ec = rd && wr;
            m_mis |= em; m_rng |= er; m_cfl |= ec;
            if (em || er || ec) m_lea = addr;
            if (rd && valid_addr(addr) && m_rc != 32'hFFFF_FFFF) m_rc++;
            if (wr && valid_addr(addr) && m_wc != 32'hFFFF_FFFF) m_wc++;
        end
        chk("err_flags", {29'b0, err_misaligned, err_range, err_conflict},
            {29'b0, m_mis, m_rng, m_cfl});
`ifdef DATA_RAM_STATS_EN
        chk("read_count", read_count, m_rc);
        chk("write_count", write_count, m_wc);
        chk("last_err_address", last_err_address, m_lea);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_mis = 0; m_rng = 0; m_cfl = 0;
        m_rc = 0; m_wc = 0; m_lea = 0;

        phase = "reset";
        cycle(1, 1, 0, 0, 32'h0, 32'h0);
        chk("reset_flags", {29'b0, err_misaligned, err_range, err_conflict}, 32'h0);

        phase = "fill";
        for (int i = 0; i < 1024; i++) cycle(0, 1, 0, 1, 32'h1000 + 32'(4 * i), $urandom());
        cycle(1, 1, 0, 0, 32'h0, 32'h0);

        phase = "t1";
        saved = model_word(32'h1000);
        cycle(0, 1, 1, 1, 32'h1000, 32'hDEADBEEF);
        chk("old_word", obs_rd, saved);
        chk("conflict_set", {31'b0, err_conflict}, 32'h1);
        cycle(0, 1, 1, 0, 32'h1000, 32'h0);
        chk("new_word", obs_rd, 32'hDEADBEEF);

        phase = "t2";
        cycle(0, 1, 0, 1, 32'h1002, 32'h1111_2222);
        chk("misaligned_set", {31'b0, err_misaligned}, 32'h1);
        cycle(0, 1, 1, 0, 32'h1000, 32'h0);
        chk("word_unchanged", obs_rd, 32'hDEADBEEF);
        cycle(0, 1, 1, 0, 32'h1002, 32'h0);
        chk("misaligned_read_zero", obs_rd, 32'h0);

        phase = "t3";
        cycle(0, 1, 1, 0, 32'h0FFC, 32'h0);
        chk("below_zero", obs_rd, 32'h0);
        chk("range_set", {31'b0, err_range}, 32'h1);
        cycle(0, 1, 1, 0, 32'h2000, 32'h0);
        chk("above_zero", obs_rd, 32'h0);
        cycle(0, 1, 1, 0, 32'hFFFF_FFFC, 32'h0);
        chk("top_zero", obs_rd, 32'h0);
        saved = ref_mem[1023];
        cycle(0, 1, 1, 0, 32'h1FFC, 32'h0);
        chk("last_word", obs_rd, saved);

        phase = "t4";
        saved = ref_mem[1];
        cycle(0, 1, 1, 1, 32'h1004, 32'h0000_1234);
        chk("prior_word", obs_rd, saved);
        cycle(0, 1, 1, 0, 32'h1004, 32'h0);
        chk("stored_word", obs_rd, 32'h0000_1234);

        phase = "t5";
        chk("all_flags_set", {29'b0, err_misaligned, err_range, err_conflict}, 32'h7);
        cycle(1, 1, 0, 1, 32'h1000, 32'hCAFE_F00D);
        chk("flags_cleared", {29'b0, err_misaligned, err_range, err_conflict}, 32'h0);
        cycle(0, 1, 1, 0, 32'h1000, 32'h0);
        chk("write_in_reset_dropped", obs_rd, 32'hDEADBEEF);
        cycle(0, 0, 1, 1, 32'h1002, 32'h77);
        chk("ce_low_no_flags", {29'b0, err_misaligned, err_range, err_conflict}, 32'h0);
        saved = ref_mem[2];
        cycle(0, 0, 0, 1, 32'h1008, 32'h5555_AAAA);
        cycle(0, 1, 1, 0, 32'h1008, 32'h0);
        chk("ce_low_write_dropped", obs_rd, saved);
        cycle(0, 0, 1, 0, 32'h1004, 32'h0);
        chk("ce_low_read_live", obs_rd, 32'h0000_1234);

`ifdef DATA_RAM_STATS_EN
        phase = "t6";
        cycle(1, 1, 0, 0, 32'h0, 32'h0);
        cycle(0, 1, 1, 0, 32'h1000, 32'h0);
        cycle(0, 1, 1, 0, 32'h1004, 32'h0);
        cycle(0, 1, 1, 0, 32'h1008, 32'h0);
        cycle(0, 1, 0, 1, 32'h100C, 32'hA5A5_0001);
        cycle(0, 1, 0, 1, 32'h1010, 32'hA5A5_0002);
        chk("read_count_3", read_count, 32'd3);
        chk("write_count_2", write_count, 32'd2);
        cycle(0, 1, 1, 0, 32'h1002, 32'h0);
        chk("last_err_1002", last_err_address, 32'h0000_1002);
        chk("read_count_held", read_count, 32'd3);
        chk("write_count_held", write_count, 32'd2);
`endif

        phase = "random";
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            int          sel;
            bit          rst, ce;
            sel = int'($urandom_range(0, 9));
            if (sel <= 6)      a = 32'h1000 + 32'(4 * $urandom_range(0, 1023));
            else if (sel == 7) a = 32'h1000 + 32'(4 * $urandom_range(0, 1023)) + 32'($urandom_range(1, 3));
            else if (sel == 8) a = 32'($urandom_range(0, 32'h0FFF));
            else               a = 32'h2000 + 32'($urandom_range(0, 32'h00FF_FFFF));
            rst = ($urandom_range(0, 39) == 0);
            ce  = rst ? 1'b1 : ($urandom_range(0, 4) != 0);
            cycle(rst, ce, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
